// File: rtl/lut_precompute_ctrl_pkg.sv
// lut_precompute_ctrl_pkg: shared state encoding and sizing constants for the LUT precompute sequencer
package lut_precompute_ctrl_pkg;
  localparam int DATA_W = 32;
  localparam int GROUP_SIZE = 3;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_F0      = 3'd1,
    S_F1      = 3'd2,
    S_F2      = 3'd3,
    S_F3      = 3'd4,
    S_LOAD    = 3'd5,
    S_COMPUTE = 3'd6,
    S_DONE    = 3'd7
  } state_e;
endpackage

// File: rtl/lut_precompute_ctrl_dff.sv
// lut_precompute_ctrl_dff: enabled register with asynchronous active-low reset
module lut_precompute_ctrl_dff #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  always_ff @(posedge clk or negedge rst_n_i)
    if (!rst_n_i) q_o <= '0;
    else if (en_i) q_o <= d_i;
endmodule

// File: rtl/lut_precompute_ctrl.sv
// lut_precompute_ctrl: walks activations in groups of three, loads the LUT preprocessor and streams one row beat per weight row
module lut_precompute_ctrl #(
  parameter int DATA_W   = lut_precompute_ctrl_pkg::DATA_W,
  parameter int ADDR_W   = 10,
  parameter int NUM_ROWS = 8,
  parameter int ROW_W    = $clog2(NUM_ROWS)
) (
  input  logic              clk,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [ADDR_W:0]   k_len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              act_rd_en_o,
  output logic [ADDR_W-1:0] act_rd_addr_o,
  input  logic [DATA_W-1:0] act_rd_data_i,
  output logic [DATA_W-1:0] act0_o,
  output logic [DATA_W-1:0] act1_o,
  output logic [DATA_W-1:0] act2_o,
  output logic              pre_dff_en_o,
  output logic              lut_valid_o,
  input  logic              lut_ready_i,
  output logic [ROW_W-1:0]  row_idx_o,
  output logic [ADDR_W-1:0] group_idx_o
);
  import lut_precompute_ctrl_pkg::*;
  localparam int BW = ADDR_W + 2;
  state_e state_q, state_d;
  logic [ADDR_W:0] k_q, k_d;
  logic [ADDR_W-1:0] g_q, g_d, rd_addr_q;
  logic [BW-1:0] base_q, base_d, addr_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic busy_q, done_q, rd_en_q, rd_vld_q, pre_q, valid_q;
  logic accept, last_row, last_grp, clr;
  logic [2:0] cap;
  logic [DATA_W-1:0] act_d;
  logic [DATA_W-1:0] act_q [3];
  always_comb begin
    accept   = valid_q & lut_ready_i;
    last_row = row_q == ROW_W'(NUM_ROWS - 1);
    last_grp = (base_q + BW'(GROUP_SIZE)) >= BW'(k_q);
    state_d  = state_q;
    k_d      = k_q;
    g_d      = g_q;
    base_d   = base_q;
    row_d    = row_q;
    case (state_q)
      S_IDLE: if (start_i) begin
        k_d     = k_len_i;
        g_d     = '0;
        base_d  = '0;
        state_d = (k_len_i == '0) ? S_DONE : S_F0;
      end
      S_F0:    state_d = S_F1;
      S_F1:    state_d = S_F2;
      S_F2:    state_d = S_F3;
      S_F3:    state_d = S_LOAD;
      S_LOAD:  state_d = S_COMPUTE;
      S_COMPUTE: if (accept) begin
        row_d = last_row ? '0 : row_q + ROW_W'(1);
        if (last_row) begin
          state_d = last_grp ? S_DONE : S_F0;
          g_d     = last_grp ? g_q : g_q + ADDR_W'(1);
          base_d  = last_grp ? base_q : base_q + BW'(GROUP_SIZE);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        g_d     = '0;
        base_d  = '0;
      end
      default: state_d = S_IDLE;
    endcase
    addr_d = base_d + (state_d == S_F1 ? BW'(1) : state_d == S_F2 ? BW'(2) : BW'(0));
  end
  // outputs are registered from next-state so they line up with the state they describe
  always_ff @(posedge clk or negedge rst_n_i)
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      g_q       <= '0;
      base_q    <= '0;
      row_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_addr_q <= '0;
      pre_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      g_q       <= g_d;
      base_q    <= base_d;
      row_q     <= row_d;
      busy_q    <= !(state_d inside {S_IDLE, S_DONE});
      done_q    <= state_d == S_DONE;
      rd_en_q   <= (state_d inside {S_F0, S_F1, S_F2}) && (addr_d < BW'(k_d));
      rd_vld_q  <= rd_en_q;
      rd_addr_q <= addr_d[ADDR_W-1:0];
      pre_q     <= state_d == S_LOAD;
      valid_q   <= state_d == S_COMPUTE;
    end
  assign clr   = state_d == S_F0;
  assign cap   = {state_q == S_F3, state_q == S_F2, state_q == S_F1};
  assign act_d = (!clr && rd_vld_q) ? act_rd_data_i : '0;
  for (genvar i = 0; i < 3; i++) begin : g_act
    lut_precompute_ctrl_dff #(.W(DATA_W)) u_act (
      .clk     (clk),
      .rst_n_i (rst_n_i),
      .en_i    (clr | cap[i]),
      .d_i     (act_d),
      .q_o     (act_q[i])
    );
  end
  assign act0_o        = act_q[0];
  assign act1_o        = act_q[1];
  assign act2_o        = act_q[2];
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign act_rd_en_o   = rd_en_q;
  assign act_rd_addr_o = rd_addr_q;
  assign pre_dff_en_o  = pre_q;
  assign lut_valid_o   = valid_q;
  assign row_idx_o     = row_q;
  assign group_idx_o   = g_q;
endmodule
